// File: rtl/modarith_arbiter_if.sv
// Request/response bundle between the point-operation sequencers and the shared add/sub unit.
// Requests use per-requester valid/ready. Responses use a one-hot valid, per-requester ready and a shared data bus.
// master = requester side, slave = arbiter side.
interface modarith_arbiter_if #(
    parameter int DATA_WIDTH = 192,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_opA;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_opB;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_op, req_opA, req_opB, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_opA, req_opB, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/modarith_arbiter.sv
// Round-robin arbiter that shares one modular add/subtract unit between NUM_REQ requesters.
// Latency: a grant in cycle T produces rsp_valid in cycle T+2. Grants can occur at most once every 3 cycles.
// Backpressure: the response is held until its requester asserts rsp_ready. No new grant is issued until that happens.
module modarith_arbiter #(
    parameter int DATA_WIDTH = 192,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_m_we,
    input  logic [DATA_WIDTH-1:0] cfg_m,
    output logic                  cfg_ready,
    modarith_arbiter_if.slave     bus,
    output logic                  busy,
    output logic [31:0]           op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [ID_W:0]   NUM_REQ_L = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mod_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, m_q;
    logic                  op_q;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       ptr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [31:0]           op_count_q;

    logic                  any_valid;
    logic [ID_W-1:0]       grant;
    logic [ID_W:0]         idx;
    logic                  grant_fire;
    logic                  rsp_fire;
    logic [ID_W-1:0]       next_ptr;

    logic [DATA_WIDTH:0]   a_x, b_x, m_x, sum_x, calc_x;

    // Round-robin search: the first valid requester at or after the pointer, wrapping.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= NUM_REQ_L) begin
                idx = idx - NUM_REQ_L;
            end
            if (!any_valid && bus.req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                grant     = idx[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && any_valid;
    assign rsp_fire   = (state_q == RESP) && bus.rsp_ready[id_q];
    assign next_ptr   = (grant == LAST_ID) ? '0 : grant + ID_W'(1);

    // Modular add/subtract on the captured operands, using one extra bit so that carries and borrows are kept.
    always_comb begin
        a_x   = {1'b0, a_q};
        b_x   = {1'b0, b_q};
        m_x   = {1'b0, m_q};
        sum_x = a_x + b_x;
        if (op_q) begin
            calc_x = (sum_x >= m_x) ? (sum_x - m_x) : sum_x;
        end else begin
            calc_x = (a_x >= b_x) ? (a_x - b_x) : (a_x + m_x - b_x);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs. Grants are issued only in IDLE, and only one response is shown at a time.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        cfg_ready     = 1'b0;
        busy          = 1'b1;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (any_valid) begin
                    bus.req_ready[grant] = 1'b1;
                    state_d              = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: the modulus config, the captured operation, the result and the completion counter.
    // The modulus is snapshotted at grant time, so a same-cycle config write does not affect the operation being captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            op_q       <= 1'b0;
            id_q       <= '0;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            op_count_q <= '0;
        end else begin
            if (cfg_m_we && (state_q == IDLE)) begin
                mod_q <= cfg_m;
            end
            if (grant_fire) begin
                a_q   <= bus.req_opA[grant*DATA_WIDTH +: DATA_WIDTH];
                b_q   <= bus.req_opB[grant*DATA_WIDTH +: DATA_WIDTH];
                m_q   <= mod_q;
                op_q  <= bus.req_op[grant];
                id_q  <= grant;
                ptr_q <= next_ptr;
            end
            if (state_q == CALC) begin
                rsp_data_q <= calc_x[DATA_WIDTH-1:0];
            end
            if (rsp_fire) begin
                op_count_q <= op_count_q + 32'd1;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_modarith_arbiter.sv
// Directed bench for modarith_arbiter using hand-computed results with M=97 and M=101.
// Inputs are driven 1 time unit after each rising edge, and outputs are checked before the next edge.
// A watchdog bounds the run.
module tb_modarith_arbiter;
    localparam int DW = 192;
    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic          cfg_m_we;
    logic [DW-1:0] cfg_m;
    logic          cfg_ready;
    logic          busy;
    logic [31:0]   op_count;

    int errors = 0;
    int checks = 0;

    modarith_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    modarith_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_m_we (cfg_m_we),
        .cfg_m    (cfg_m),
        .cfg_ready(cfg_ready),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input bit op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_op[id]             = op;
        bus.req_opA[id*DW +: DW]   = a;
        bus.req_opB[id*DW +: DW]   = b;
    endtask

    // Single-requester operation with zero-wait accept. It can optionally write M=101 in the grant cycle.
    task automatic do_op(input int id, input bit op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp, input bit cfg_wr, input string tag);
        logic [NR-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        set_req(id, op, a, b);
        bus.req_valid = oh;
        if (cfg_wr) begin
            cfg_m_we = 1'b1;
            cfg_m    = 192'd101;
        end
        #1;
        chk({tag, "_grant"}, bus.req_ready, oh);
        if (cfg_wr) chk({tag, "_cfg_ready"}, cfg_ready, 1);
        tick();
        bus.req_valid = '0;
        cfg_m_we      = 1'b0;
        chk({tag, "_calc_rdy"}, bus.req_ready, 0);
        chk({tag, "_calc_vld"}, bus.rsp_valid, 0);
        tick();
        chk({tag, "_rsp_vld"}, bus.rsp_valid, oh);
        chk({tag, "_rsp_data"}, bus.rsp_data, exp);
        bus.rsp_ready = oh;
        tick();
        bus.rsp_ready = '0;
    endtask

    initial begin
        logic [NR-1:0]  oh;
        logic [31:0]    cnt;
        rst_n         = 1'b0;
        cfg_m_we      = 1'b0;
        cfg_m         = '0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_opA   = '0;
        bus.req_opB   = '0;
        bus.rsp_ready = '0;

        // Reset state.
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load M=97, then req0 sub 10-30 -> 77.
        cfg_m_we = 1'b1;
        cfg_m    = 192'd97;
        tick();
        cfg_m_we = 1'b0;
        do_op(0, 1'b0, 192'd10, 192'd30, 192'd77, 1'b0, "sub_wrap");
        chk("count_1", op_count, 1);

        // Add with and without reduction, and a subtract that gives zero.
        do_op(2, 1'b1, 192'd90, 192'd20, 192'd13, 1'b0, "add_red");
        do_op(2, 1'b1, 192'd40, 192'd50, 192'd90, 1'b0, "add_nored");
        do_op(2, 1'b0, 192'd55, 192'd55, 192'd0, 1'b0, "sub_zero");
        chk("count_4", op_count, 4);

        // Reset to put the pointer back at 0, then reload M.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        cfg_m_we = 1'b1;
        cfg_m    = 192'd97;
        tick();
        cfg_m_we = 1'b0;

        // All four requesters valid, with zero-wait accept. Requester i computes (i+1)+10 mod 97.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 192'(i + 1), 192'd10);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            oh = '0;
            oh[g % NR] = 1'b1;
            chk($sformatf("rr_grant%0d", g), bus.req_ready, oh);
            tick();
            chk($sformatf("rr_calc_rdy%0d", g), bus.req_ready, 0);
            tick();
            chk($sformatf("rr_rsp_vld%0d", g), bus.rsp_valid, oh);
            chk($sformatf("rr_rsp_data%0d", g), bus.rsp_data, 192'((g % NR) + 11));
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        chk("rr_count_5", op_count, 5);

        // Grant to req1 with req3 pending. Hold the response for 10 cycles with other ready bits set.
        set_req(1, 1'b0, 192'd20, 192'd50);
        set_req(3, 1'b0, 192'd60, 192'd6);
        bus.req_valid = 4'b1010;
        #1;
        chk("bp_grant1", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        bus.rsp_ready = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("bp_vld_c%0d", c), bus.rsp_valid, 4'b0010);
            chk($sformatf("bp_data_c%0d", c), bus.rsp_data, 192'd67);
            chk($sformatf("bp_rdy_c%0d", c), bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 4'b0010;
        tick();
        bus.rsp_ready = '0;
        chk("bp_grant3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick();
        chk("bp_rsp3_vld", bus.rsp_valid, 4'b1000);
        chk("bp_rsp3_data", bus.rsp_data, 192'd54);
        bus.rsp_ready = 4'b1000;
        tick();
        bus.rsp_ready = '0;
        chk("bp_count", op_count, 7);

        // A cfg write during CALC and RESP is ignored.
        set_req(0, 1'b1, 192'd50, 192'd60);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        cfg_m_we = 1'b1;
        cfg_m    = 192'd101;
        chk("cfg_calc_ready", cfg_ready, 0);
        tick();
        chk("cfg_resp_ready", cfg_ready, 0);
        chk("cfg_resp_data", bus.rsp_data, 192'd13);
        bus.rsp_ready = 4'b0001;
        tick();
        cfg_m_we      = 1'b0;
        bus.rsp_ready = '0;
        do_op(0, 1'b1, 192'd50, 192'd60, 192'd13, 1'b0, "cfg_ignored");
        // A write in IDLE during the same cycle as a grant: the old M applies to this op, and the new M to the next one.
        do_op(1, 1'b1, 192'd50, 192'd60, 192'd13, 1'b1, "cfg_same_cyc");
        do_op(1, 1'b1, 192'd50, 192'd60, 192'd9, 1'b0, "cfg_new_m");
        chk("cfg_count", op_count, 11);

        // Reset during CALC. Outputs clear asynchronously and no response follows.
        set_req(2, 1'b0, 192'd10, 192'd3);
        bus.req_valid = 4'b0100;
        #1;
        chk("arst_grant2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        chk("arst_in_calc", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rsp_data", bus.rsp_data, 0);
        chk("arst_op_count", op_count, 0);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.rsp_valid != '0) cnt++;
            tick();
        end
        chk("arst_no_rsp", cnt, 0);

        // After reset the pointer is back at 0, so req0 wins over req3.
        cfg_m_we = 1'b1;
        cfg_m    = 192'd97;
        tick();
        cfg_m_we = 1'b0;
        set_req(0, 1'b1, 192'd1, 192'd2);
        set_req(3, 1'b1, 192'd5, 192'd5);
        bus.req_valid = 4'b1001;
        #1;
        chk("arst_ptr0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        tick();
        chk("arst_rsp_vld", bus.rsp_valid, 4'b0001);
        chk("arst_rsp_val", bus.rsp_data, 192'd3);
        bus.rsp_ready = 4'b0001;
        tick();
        bus.rsp_ready = '0;
        chk("arst_count1", op_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
